// File: rtl/uart_pkg.sv
// uart_pkg: framing constants and receiver state type shared by the UART blocks
package uart_pkg;
   localparam int DATA_BITS_DEF    = 8;
   localparam int CLKS_PER_BIT_DEF = 100;
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} rx_state_t;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for an asynchronous single-bit input
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);
   logic meta;
   // Two back-to-back flops give the first one a full cycle to settle
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
endmodule

// File: rtl/receiver.sv
// receiver: 8N1 UART receive path with mid-bit sampling and framing-error detection
module receiver
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int DATA_BITS    = DATA_BITS_DEF
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_rx,
   output logic [DATA_BITS-1:0] o_data,
   output logic                 o_rx_done,
   output logic                 o_frame_err,
   output logic                 o_busy
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

   rx_state_t            state;
   logic [CW-1:0]        clk_cnt;
   logic [BW-1:0]        bit_idx;
   logic [DATA_BITS-1:0] shreg;
   logic                 rx_s;

   sync_2ff #(.RST_VAL(1'b1)) u_sync (
      .clk  (i_clk),
      .rst_n(i_rst_n),
      .d    (i_rx),
      .q    (rx_s)
   );

   assign o_busy = (state != IDLE);

   // Frame FSM: half-bit wait to centre on the start bit, then whole-bit steps; pulses default low
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         state       <= IDLE;
         clk_cnt     <= '0;
         bit_idx     <= '0;
         shreg       <= '0;
         o_data      <= '0;
         o_rx_done   <= 1'b0;
         o_frame_err <= 1'b0;
      end else begin
         o_rx_done   <= 1'b0;
         o_frame_err <= 1'b0;
         case (state)
            IDLE:
               if (!rx_s) begin
                  state   <= START;
                  clk_cnt <= '0;
               end
            START:
               if (clk_cnt == HALF_M1) begin
                  clk_cnt <= '0;
                  bit_idx <= '0;
                  state   <= rx_s ? IDLE : DATA;
               end else clk_cnt <= clk_cnt + CW'(1);
            DATA:
               if (clk_cnt == FULL_M1) begin
                  clk_cnt <= '0;
                  shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                  bit_idx <= bit_idx + BW'(1);
                  if (bit_idx == LAST_BIT) state <= STOP;
               end else clk_cnt <= clk_cnt + CW'(1);
            STOP:
               if (clk_cnt == FULL_M1) begin
                  clk_cnt <= '0;
                  if (rx_s) begin
                     o_data    <= shreg;
                     o_rx_done <= 1'b1;
                     state     <= IDLE;
                  end else begin
                     o_frame_err <= 1'b1;
                     state       <= WAIT_IDLE;
                  end
               end else clk_cnt <= clk_cnt + CW'(1);
            WAIT_IDLE:
               if (rx_s) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
endmodule
